// File: rtl/pwr_seq_if.sv
// rtl/pwr_seq_if.sv - CPU/memory/timer request and clock-control signals of the power sequencer
interface pwr_seq_if #(
   parameter int TIMER_W = 24
);
   logic               wfi;
   logic               dm_busy;
   logic               wake_ext;
   logic               timer_load;
   logic [TIMER_W-1:0] timer_value;
   logic               pll_bypass;
   logic               core_clk_en;
   logic               cpu_stall;
   logic               sleeping;
   logic [1:0]         wake_cause;

   modport master (
      output wfi, dm_busy, wake_ext, timer_load, timer_value,
      input  pll_bypass, core_clk_en, cpu_stall, sleeping, wake_cause
   );

   modport slave (
      input  wfi, dm_busy, wake_ext, timer_load, timer_value,
      output pll_bypass, core_clk_en, cpu_stall, sleeping, wake_cause
   );
endinterface

// File: rtl/pwr_seq.sv
// rtl/pwr_seq.sv - always-on sleep/wake sequencer: drain, bypass PLL, gate core clock, and back
module pwr_seq #(
   parameter int SETTLE_CYCLES = 16,
   parameter int LOCK_CYCLES   = 64,
   parameter int TIMER_W       = 24
) (
   input  logic     i_clk,
   input  logic     i_reset,
   pwr_seq_if.slave io_pwr
);
   typedef enum logic [2:0] {
      S_RUN, S_DRAIN, S_BYPASS, S_SLEEP, S_RELOCK, S_RESUME
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [11:0]        r_cnt;
   logic [TIMER_W-1:0] r_timer;
   logic [1:0]         r_wake_lat;
   logic               r_armed;
   logic               r_pll_bypass;
   logic               r_core_clk_en;
   logic               r_cpu_stall;
   logic               r_sleeping;
   logic [1:0]         r_wake_cause;
   logic               w_pll_bypass;
   logic               w_core_clk_en;
   logic               w_cpu_stall;
   logic               w_sleeping;
   logic               w_tmr_fire;
   logic [1:0]         w_wake_now;
   logic [1:0]         w_wake_any;
   logic               w_cnt_zero;

   // A load in the expiry cycle wins, so the timer only fires when not being reloaded.
   assign w_tmr_fire = !io_pwr.timer_load && (r_timer == TIMER_W'(1));
   assign w_wake_now = {w_tmr_fire, io_pwr.wake_ext};
   // Wakes that arrived during BYPASS are merged with any arriving in SLEEP itself.
   assign w_wake_any = w_wake_now | r_wake_lat;
   assign w_cnt_zero = (r_cnt == 12'd0);

   // State register, registered outputs and wake cause capture.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_RUN;
         r_pll_bypass  <= 1'b0;
         r_core_clk_en <= 1'b1;
         r_cpu_stall   <= 1'b0;
         r_sleeping    <= 1'b0;
         r_wake_cause  <= 2'b00;
      end else begin
         r_state       <= w_next;
         r_pll_bypass  <= w_pll_bypass;
         r_core_clk_en <= w_core_clk_en;
         r_cpu_stall   <= w_cpu_stall;
         r_sleeping    <= w_sleeping;
         if (r_state == S_SLEEP && w_next == S_RELOCK) begin
            r_wake_cause <= w_wake_any;
         end
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RUN:    if (io_pwr.wfi && r_armed) w_next = S_DRAIN;
         S_DRAIN:  begin
            if (!io_pwr.wfi)          w_next = S_RUN;
            else if (!io_pwr.dm_busy) w_next = S_BYPASS;
         end
         S_BYPASS: if (w_cnt_zero)    w_next = S_SLEEP;
         S_SLEEP:  if (|w_wake_any)   w_next = S_RELOCK;
         S_RELOCK: if (w_cnt_zero)    w_next = S_RESUME;
         S_RESUME: w_next = S_RUN;
         default:  w_next = S_RUN;
      endcase
   end

   // Outputs decoded from the state being entered, so they register alongside it.
   always_comb begin
      w_pll_bypass  = 1'b0;
      w_core_clk_en = 1'b1;
      w_cpu_stall   = 1'b0;
      w_sleeping    = 1'b0;
      case (w_next)
         S_DRAIN:  w_cpu_stall = 1'b1;
         S_BYPASS: begin
            w_pll_bypass = 1'b1;
            w_cpu_stall  = 1'b1;
         end
         S_SLEEP:  begin
            w_pll_bypass  = 1'b1;
            w_core_clk_en = 1'b0;
            w_cpu_stall   = 1'b1;
            w_sleeping    = 1'b1;
         end
         S_RELOCK: begin
            w_core_clk_en = 1'b0;
            w_cpu_stall   = 1'b1;
         end
         S_RESUME: w_cpu_stall = 1'b1;
         default:  w_cpu_stall = 1'b0;
      endcase
   end

   // Shared settle/relock down-counter, preset on entry to BYPASS or RELOCK.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= 12'd0;
      end else if (r_state != S_BYPASS && w_next == S_BYPASS) begin
         r_cnt <= 12'(SETTLE_CYCLES - 1);
      end else if (r_state != S_RELOCK && w_next == S_RELOCK) begin
         r_cnt <= 12'(LOCK_CYCLES - 1);
      end else if (!w_cnt_zero) begin
         r_cnt <= r_cnt - 12'd1;
      end
   end

   // Wake timer: counts down in every state, fires once on 1->0, then rests at 0.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_timer <= '0;
      end else if (io_pwr.timer_load) begin
         r_timer <= io_pwr.timer_value;
      end else if (r_timer != '0) begin
         r_timer <= r_timer - TIMER_W'(1);
      end
   end

   // Hold wakes seen while settling in BYPASS until SLEEP can act on them.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wake_lat <= 2'b00;
      end else if (r_state == S_BYPASS) begin
         r_wake_lat <= r_wake_lat | w_wake_now;
      end else begin
         r_wake_lat <= 2'b00;
      end
   end

   // wfi must be seen low before another sleep, so a still-high wfi after wake cannot loop.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_armed <= 1'b0;
      end else if (!io_pwr.wfi) begin
         r_armed <= 1'b1;
      end else if (r_state == S_RUN && w_next == S_DRAIN) begin
         r_armed <= 1'b0;
      end
   end

   assign io_pwr.pll_bypass  = r_pll_bypass;
   assign io_pwr.core_clk_en = r_core_clk_en;
   assign io_pwr.cpu_stall   = r_cpu_stall;
   assign io_pwr.sleeping    = r_sleeping;
   assign io_pwr.wake_cause  = r_wake_cause;
endmodule
